// File: rtl/rr_arbiter_ctrl.sv
// Round-robin arbiter for 8 requesters sharing one resource.
// Rotating priority starts just after the last granted index. A grant is
// non-preemptive and ends when the owner releases it, drops its request, or
// (when MAX_HOLD is non-zero) after MAX_HOLD cycles with a timeout pulse.
// The owner's release strobe is named owner_release because "release" is a
// reserved word in SystemVerilog.
module rr_arbiter_ctrl #(
  parameter int N        = 8,
  parameter int MAX_HOLD = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic                 owner_release,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_idx,
  output logic                 grant_valid,
  output logic                 timeout
);

  localparam int IDX_W = $clog2(N);
  // At least one bit so the counter stays legal when timeouts are disabled.
  localparam int CNT_W = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_HOLD - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  logic [0:0]       state;
  logic [IDX_W-1:0] ptr;
  logic [CNT_W-1:0] hold_cnt;
  logic [IDX_W-1:0] pick;
  logic             end_a;
  logic             end_b;

  // First set request scanning ptr+1, ptr+2, ... ptr; the index adder wraps
  // naturally because N is a power of two.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N-1:0] r,
                                               input logic [IDX_W-1:0] p);
    logic [IDX_W-1:0] idx;
    logic             found;
    rr_pick = p;
    found   = 1'b0;
    for (int k = 1; k <= N; k++) begin
      idx = p + IDX_W'(k);
      if (!found && r[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  function automatic logic [N-1:0] onehot(input logic [IDX_W-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

  // Next winner and the two ways a held grant can end.
  always_comb begin
    pick  = rr_pick(req, ptr);
    end_a = owner_release || !req[grant_idx];
    end_b = (MAX_HOLD != 0) && (hold_cnt == CNT_LAST);
  end

  // Arbitration FSM: grant from IDLE, hold in BUSY, one dead cycle between grants.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      grant       <= '0;
      grant_idx   <= '0;
      grant_valid <= 1'b0;
      timeout     <= 1'b0;
      hold_cnt    <= '0;
      ptr         <= IDX_W'(N - 1);
    end else begin
      case (state)
        ST_IDLE: begin
          timeout <= 1'b0;
          if (|req) begin
            grant       <= onehot(pick);
            grant_idx   <= pick;
            grant_valid <= 1'b1;
            ptr         <= pick;
            hold_cnt    <= '0;
            state       <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          // A normal end takes precedence over the timeout in the same cycle.
          if (end_a) begin
            grant       <= '0;
            grant_valid <= 1'b0;
            timeout     <= 1'b0;
            state       <= ST_IDLE;
          end else if (end_b) begin
            grant       <= '0;
            grant_valid <= 1'b0;
            timeout     <= 1'b1;
            state       <= ST_IDLE;
          end
          if (hold_cnt != CNT_SAT) begin
            hold_cnt <= hold_cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter_ctrl.sv
// Bench for rr_arbiter_ctrl: two instances (MAX_HOLD 16 and 4) share stimulus;
// a cycle-level model of the arbitration rules is checked every cycle, and
// directed scenarios add hand-computed literal expectations.
module tb_rr_arbiter_ctrl;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic       owner_release;

  logic [7:0] grant_a, grant_b;
  logic [2:0] idx_a, idx_b;
  logic       gv_a, gv_b;
  logic       to_a, to_b;

  int total = 0;
  int bad   = 0;

  // Model state per instance: index 0 is MAX_HOLD=16, index 1 is MAX_HOLD=4.
  int mh[2] = '{16, 4};
  bit m_busy[2];
  int m_idx[2];
  int m_ptr[2];
  int m_len[2];
  bit m_to[2];

  rr_arbiter_ctrl #(.N(8), .MAX_HOLD(16)) dut_a (
    .clk(clk), .rst(rst), .req(req), .owner_release(owner_release),
    .grant(grant_a), .grant_idx(idx_a), .grant_valid(gv_a), .timeout(to_a)
  );

  rr_arbiter_ctrl #(.N(8), .MAX_HOLD(4)) dut_b (
    .clk(clk), .rst(rst), .req(req), .owner_release(owner_release),
    .grant(grant_b), .grant_idx(idx_b), .grant_valid(gv_b), .timeout(to_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs about to be sampled.
  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_busy[i] = 1'b0; m_idx[i] = 0; m_ptr[i] = 7; m_len[i] = 0; m_to[i] = 1'b0;
      end else if (!m_busy[i]) begin
        m_to[i] = 1'b0;
        if (req != 8'h00) begin
          bit found = 1'b0;
          for (int k = 1; k <= 8; k++) begin
            int c = (m_ptr[i] + k) % 8;
            if (!found && req[c]) begin
              found = 1'b1;
              m_idx[i] = c;
            end
          end
          m_ptr[i]  = m_idx[i];
          m_busy[i] = 1'b1;
          m_len[i]  = 1;
        end
      end else begin
        if (owner_release || !req[m_idx[i]]) begin
          m_busy[i] = 1'b0; m_to[i] = 1'b0;
        end else if (mh[i] != 0 && m_len[i] == mh[i]) begin
          m_busy[i] = 1'b0; m_to[i] = 1'b1;
        end else begin
          m_len[i]++;
        end
      end
    end
  endtask

  task automatic check_one(input string nm, input int i, input logic [7:0] g,
                           input logic [2:0] gi, input logic gv, input logic to);
    logic [7:0] eg;
    eg = m_busy[i] ? 8'(1 << m_idx[i]) : 8'h00;
    cmp({nm, ".grant"}, 32'(g), 32'(eg));
    cmp({nm, ".grant_idx"}, 32'(gi), 32'(m_idx[i]));
    cmp({nm, ".grant_valid"}, 32'(gv), 32'(m_busy[i]));
    cmp({nm, ".timeout"}, 32'(to), 32'(m_to[i]));
  endtask

  task automatic check_all();
    check_one("model_a", 0, grant_a, idx_a, gv_a, to_a);
    check_one("model_b", 1, grant_b, idx_b, gv_b, to_b);
  endtask

  // Drive one cycle of inputs away from the rising edge, then check just after it.
  task automatic step(input logic [7:0] r, input logic rl, input logic rs);
    @(negedge clk);
    req = r; owner_release = rl; rst = rs;
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    step(8'h00, 1'b0, 1'b1);
    step(8'h00, 1'b0, 1'b1);
  endtask

  initial begin
    logic [7:0] oh;
    rst = 1'b1; req = 8'h00; owner_release = 1'b0;

    // Reset state and first grant.
    do_reset();
    cmp("rst_grant", 32'(grant_a), 32'h00);
    cmp("rst_valid", 32'(gv_a), 32'h0);
    cmp("rst_idx", 32'(idx_a), 32'h0);
    cmp("rst_timeout", 32'(to_a), 32'h0);
    step(8'h01, 1'b0, 1'b0);
    cmp("t1_grant", 32'(grant_a), 32'h01);
    cmp("t1_idx", 32'(idx_a), 32'h0);
    cmp("t1_valid", 32'(gv_a), 32'h1);
    step(8'h01, 1'b1, 1'b0);
    cmp("t1_release_valid", 32'(gv_a), 32'h0);

    // Full rotation with release on every grant cycle.
    do_reset();
    for (int k = 0; k < 9; k++) begin
      step(8'hFF, 1'b0, 1'b0);
      oh = 8'h01 << (k % 8);
      cmp("t2_idx", 32'(idx_a), 32'(k % 8));
      cmp("t2_grant", 32'(grant_b), 32'(oh));
      step(8'hFF, 1'b1, 1'b0);
      cmp("t2_gap", 32'(gv_a), 32'h0);
    end

    // Pointer after idx 5: request 0 and 5 together goes to 0.
    do_reset();
    step(8'h20, 1'b0, 1'b0);
    cmp("t3_first", 32'(idx_a), 32'h5);
    step(8'h20, 1'b1, 1'b0);
    step(8'h21, 1'b0, 1'b0);
    cmp("t3_grant", 32'(grant_a), 32'h01);
    cmp("t3_idx", 32'(idx_a), 32'h0);
    step(8'h00, 1'b0, 1'b0);

    // Release while idle is ignored; other req bits ignored while busy.
    do_reset();
    step(8'h00, 1'b1, 1'b0);
    step(8'h02, 1'b0, 1'b0);
    cmp("idle_rel_idx", 32'(idx_a), 32'h1);
    step(8'h0E, 1'b0, 1'b0);
    cmp("hold_grant", 32'(grant_a), 32'h02);
    step(8'h00, 1'b0, 1'b0);
    step(8'h00, 1'b0, 1'b0);

    // Timeout with MAX_HOLD=4 (instance b) and MAX_HOLD=16 (instance a).
    do_reset();
    for (int k = 1; k <= 4; k++) begin
      step(8'h04, 1'b0, 1'b0);
      cmp("t4_valid", 32'(gv_b), 32'h1);
    end
    step(8'h04, 1'b0, 1'b0);
    cmp("t4_gap_valid", 32'(gv_b), 32'h0);
    cmp("t4_timeout", 32'(to_b), 32'h1);
    step(8'h04, 1'b0, 1'b0);
    cmp("t4_regrant", 32'(grant_b), 32'h04);
    cmp("t4_to_clear", 32'(to_b), 32'h0);
    for (int k = 7; k <= 16; k++) step(8'h04, 1'b0, 1'b0);
    cmp("t4a_valid16", 32'(gv_a), 32'h1);
    step(8'h04, 1'b0, 1'b0);
    cmp("t4a_timeout", 32'(to_a), 32'h1);
    step(8'h00, 1'b0, 1'b0);
    step(8'h00, 1'b0, 1'b0);

    // Reset in the middle of a grant.
    do_reset();
    step(8'h08, 1'b0, 1'b0);
    cmp("t5_grant", 32'(grant_a), 32'h08);
    step(8'h08, 1'b0, 1'b1);
    cmp("t5_rst_grant", 32'(grant_a), 32'h00);
    cmp("t5_rst_idx", 32'(idx_a), 32'h0);
    cmp("t5_rst_to", 32'(to_a), 32'h0);
    step(8'h88, 1'b0, 1'b0);
    cmp("t5_idx", 32'(idx_a), 32'h3);
    step(8'h00, 1'b0, 1'b0);

    // Release in the 4th cycle beats the timeout on instance b.
    do_reset();
    for (int k = 1; k <= 4; k++) step(8'h04, 1'b0, 1'b0);
    step(8'h04, 1'b1, 1'b0);
    cmp("t6_valid", 32'(gv_b), 32'h0);
    cmp("t6_timeout", 32'(to_b), 32'h0);
    step(8'h00, 1'b0, 1'b0);
    step(8'h00, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
